// File: rtl/ex_mem_stage_reg_pkg.sv
// Shared types for the EX->MEM boundary: NZVC flag bundle and MEM/WB control bundle.
package ex_mem_stage_reg_pkg;

    localparam int DATA_W_DEFAULT   = 64;
    localparam int REG_W_DEFAULT    = 5;
    localparam int ZERO_REG_DEFAULT = 31;

    typedef struct packed {
        logic negative;
        logic zero;
        logic overflow;
        logic carry;
    } alu_flags;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic reg_write;
    } mem_ctrl_t;

    // A bubble carries no control at all, and nothing may ever write XZR.
    function automatic mem_ctrl_t qualify_ctrl(
        input logic      valid,
        input mem_ctrl_t ctrl,
        input logic      rd_is_zero
    );
        mem_ctrl_t q;
        q = '0;
        if (valid) begin
            q = ctrl;
            if (rd_is_zero) begin
                q.reg_write = 1'b0;
            end
        end
        return q;
    endfunction

endpackage

// File: rtl/ex_mem_stage_reg_flag_reg.sv
// Architectural NZVC register with a same-cycle bypass of the flags produced in EX.
module flag_reg
    import ex_mem_stage_reg_pkg::*;
(
    input  logic     clk,
    input  logic     reset_n,
    input  logic     stall,
    input  logic     flush,
    input  logic     ex_valid,
    input  logic     ex_set_flags,
    input  alu_flags ex_flags,
    output alu_flags flags_q,
    output alu_flags br_flags
);

    logic ex_writes_flags;

    assign ex_writes_flags = ex_valid & ex_set_flags & ~flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q <= '0;
        end else if (ex_writes_flags && !stall) begin
            flags_q <= ex_flags;
        end
    end

    // Bypass still follows EX under stall: the setter has not committed yet but B.cond must see it.
    assign br_flags = ex_writes_flags ? ex_flags : flags_q;

endmodule

// File: rtl/ex_mem_stage_reg.sv
// EX->MEM pipeline register: result, store data, destination and MEM/WB control, plus NZVC flags.
module ex_mem_stage_reg
    import ex_mem_stage_reg_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEFAULT,
    parameter int REG_W    = REG_W_DEFAULT,
    parameter int ZERO_REG = ZERO_REG_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_data_out,
    input  alu_flags          ex_flags,
    input  logic              ex_set_flags,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_W-1:0]  ex_rd,
    input  mem_ctrl_t         ex_ctrl,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_addr_data,
    output logic [DATA_W-1:0] mem_store_data,
    output logic [REG_W-1:0]  mem_rd,
    output mem_ctrl_t         mem_ctrl,
    output alu_flags          flags_q,
    output alu_flags          br_flags
);

    mem_ctrl_t load_ctrl;
    logic      rd_is_zero;

    assign rd_is_zero = (ex_rd == REG_W'(ZERO_REG));
    assign load_ctrl  = qualify_ctrl(ex_valid, ex_ctrl, rd_is_zero);

    // Flush wins over stall; on a flush the data fields simply hold since nothing will consume them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_valid      <= 1'b0;
            mem_addr_data  <= '0;
            mem_store_data <= '0;
            mem_rd         <= '0;
            mem_ctrl       <= '0;
        end else if (flush) begin
            mem_valid <= 1'b0;
            mem_ctrl  <= '0;
        end else if (!stall) begin
            mem_valid      <= ex_valid;
            mem_addr_data  <= ex_data_out;
            mem_store_data <= ex_store_data;
            mem_rd         <= ex_rd;
            mem_ctrl       <= load_ctrl;
        end
    end

    flag_reg u_flag_reg (
        .clk          (clk),
        .reset_n      (reset_n),
        .stall        (stall),
        .flush        (flush),
        .ex_valid     (ex_valid),
        .ex_set_flags (ex_set_flags),
        .ex_flags     (ex_flags),
        .flags_q      (flags_q),
        .br_flags     (br_flags)
    );

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Bench for ex_mem_stage_reg: directed scenarios with literal expectations, then randomized traffic.
module tb_ex_mem_stage_reg;
    import ex_mem_stage_reg_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        flush;
    logic        ex_valid;
    logic [63:0] ex_data_out;
    alu_flags    ex_flags;
    logic        ex_set_flags;
    logic [63:0] ex_store_data;
    logic [4:0]  ex_rd;
    mem_ctrl_t   ex_ctrl;
    logic        mem_valid;
    logic [63:0] mem_addr_data;
    logic [63:0] mem_store_data;
    logic [4:0]  mem_rd;
    mem_ctrl_t   mem_ctrl;
    alu_flags    flags_q;
    alu_flags    br_flags;

    int checks = 0;
    int errors = 0;

    logic        m_valid = 1'b0;
    logic [63:0] m_addr  = '0;
    logic [63:0] m_store = '0;
    logic [4:0]  m_rd    = '0;
    logic [3:0]  m_ctrl  = '0;
    logic [3:0]  m_flags = '0;

    ex_mem_stage_reg dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .stall          (stall),
        .flush          (flush),
        .ex_valid       (ex_valid),
        .ex_data_out    (ex_data_out),
        .ex_flags       (ex_flags),
        .ex_set_flags   (ex_set_flags),
        .ex_store_data  (ex_store_data),
        .ex_rd          (ex_rd),
        .ex_ctrl        (ex_ctrl),
        .mem_valid      (mem_valid),
        .mem_addr_data  (mem_addr_data),
        .mem_store_data (mem_store_data),
        .mem_rd         (mem_rd),
        .mem_ctrl       (mem_ctrl),
        .flags_q        (flags_q),
        .br_flags       (br_flags)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(
        input logic        v,
        input logic [63:0] data,
        input logic [63:0] sdata,
        input logic [4:0]  rd,
        input logic [3:0]  ctrl,
        input logic        setf,
        input logic [3:0]  flags,
        input logic        st,
        input logic        fl
    );
        ex_valid      = v;
        ex_data_out   = data;
        ex_store_data = sdata;
        ex_rd         = rd;
        ex_ctrl       = ctrl;
        ex_set_flags  = setf;
        ex_flags      = flags;
        stall         = st;
        flush         = fl;
    endtask

    // Reference model: what the MEM side must hold after each edge.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid <= 1'b0;
            m_addr  <= '0;
            m_store <= '0;
            m_rd    <= '0;
            m_ctrl  <= '0;
            m_flags <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
            m_ctrl  <= '0;
        end else if (!stall) begin
            m_valid <= ex_valid;
            m_addr  <= ex_data_out;
            m_store <= ex_store_data;
            m_rd    <= ex_rd;
            m_ctrl  <= ex_valid ? {ex_ctrl.mem_read, ex_ctrl.mem_write, ex_ctrl.mem_to_reg,
                                   ex_ctrl.reg_write && (ex_rd != 5'd31)} : 4'd0;
            if (ex_valid && ex_set_flags) begin
                m_flags <= ex_flags;
            end
        end
    end

    always @(negedge clk) begin
        logic [3:0] exp_br;
        exp_br = (ex_valid && ex_set_flags && !flush) ? ex_flags : m_flags;
        checkOutput("mem_valid", {63'd0, mem_valid}, {63'd0, m_valid});
        checkOutput("mem_addr_data", mem_addr_data, m_addr);
        checkOutput("mem_store_data", mem_store_data, m_store);
        checkOutput("mem_rd", {59'd0, mem_rd}, {59'd0, m_rd});
        checkOutput("mem_ctrl", {60'd0, mem_ctrl}, {60'd0, m_ctrl});
        checkOutput("flags_q", {60'd0, flags_q}, {60'd0, m_flags});
        checkOutput("br_flags", {60'd0, br_flags}, {60'd0, exp_br});
    end

    initial begin
        reset_n = 1'b0;
        applyStimulus(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom), 4'($urandom),
                      1'b1, 4'($urandom), 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", {63'd0, mem_valid}, 64'd0);
        checkOutput("rst_addr", mem_addr_data, 64'd0);
        checkOutput("rst_store", mem_store_data, 64'd0);
        checkOutput("rst_rd", {59'd0, mem_rd}, 64'd0);
        checkOutput("rst_ctrl", {60'd0, mem_ctrl}, 64'd0);
        checkOutput("rst_flags", {60'd0, flags_q}, 64'd0);

        // First edge after release loads
        applyStimulus(1'b1, 64'h55, 64'h66, 5'd3, 4'b1010, 1'b0, 4'b0000, 1'b0, 1'b0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("first_valid", {63'd0, mem_valid}, 64'd1);
        checkOutput("first_addr", mem_addr_data, 64'h55);
        checkOutput("first_ctrl", {60'd0, mem_ctrl}, 64'b1010);

        applyStimulus(1'b1, 64'h1234, 64'h0, 5'd5, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
        @(posedge clk); #1;
        checkOutput("load_addr", mem_addr_data, 64'h1234);
        checkOutput("load_rd", {59'd0, mem_rd}, 64'd5);
        checkOutput("load_regwrite", {63'd0, mem_ctrl.reg_write}, 64'd1);
        checkOutput("load_valid", {63'd0, mem_valid}, 64'd1);

        applyStimulus(1'b1, 64'h77, 64'h0, 5'd31, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
        @(posedge clk); #1;
        checkOutput("xzr_regwrite", {63'd0, mem_ctrl.reg_write}, 64'd0);
        checkOutput("xzr_valid", {63'd0, mem_valid}, 64'd1);

        applyStimulus(1'b1, 64'h0, 64'h0, 5'd9, 4'b0001, 1'b1, 4'b0100, 1'b0, 1'b0);
        #1;
        checkOutput("subs_bypass_zero", {63'd0, br_flags.zero}, 64'd1);
        @(posedge clk); #1;
        checkOutput("subs_flags_zero", {63'd0, flags_q.zero}, 64'd1);
        applyStimulus(1'b1, 64'h10, 64'h0, 5'd10, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
        @(posedge clk); #1;
        checkOutput("add_keeps_zero", {63'd0, flags_q.zero}, 64'd1);

        applyStimulus(1'b1, 64'hABCD, 64'hBEEF, 5'd7, 4'b0110, 1'b0, 4'b1111, 1'b0, 1'b0);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom),
                          4'($urandom), 1'b1, 4'($urandom), 1'b1, 1'b0);
            @(posedge clk); #1;
            checkOutput("stall_addr", mem_addr_data, 64'hABCD);
            checkOutput("stall_store", mem_store_data, 64'hBEEF);
            checkOutput("stall_rd", {59'd0, mem_rd}, 64'd7);
            checkOutput("stall_ctrl", {60'd0, mem_ctrl}, 64'b0110);
            checkOutput("stall_valid", {63'd0, mem_valid}, 64'd1);
            checkOutput("stall_flags", {60'd0, flags_q}, 64'b0100);
        end

        applyStimulus(1'b1, {$urandom, $urandom}, 64'h0, 5'd4, 4'b0001, 1'b1, 4'b1000, 1'b1, 1'b1);
        #1;
        checkOutput("stflush_br", {60'd0, br_flags}, 64'b0100);
        @(posedge clk); #1;
        checkOutput("stflush_valid", {63'd0, mem_valid}, 64'd0);
        checkOutput("stflush_ctrl", {60'd0, mem_ctrl}, 64'd0);
        checkOutput("stflush_flags", {60'd0, flags_q}, 64'b0100);

        applyStimulus(1'b1, 64'h99, 64'h98, 5'd12, 4'b1001, 1'b1, 4'b0011, 1'b0, 1'b0);
        @(posedge clk); #1;
        checkOutput("pre_areset_valid", {63'd0, mem_valid}, 64'd1);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("areset_valid", {63'd0, mem_valid}, 64'd0);
        checkOutput("areset_addr", mem_addr_data, 64'd0);
        checkOutput("areset_store", mem_store_data, 64'd0);
        checkOutput("areset_rd", {59'd0, mem_rd}, 64'd0);
        checkOutput("areset_ctrl", {60'd0, mem_ctrl}, 64'd0);
        checkOutput("areset_flags", {60'd0, flags_q}, 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            logic v;
            v = ($urandom_range(0, 9) < 7);
            applyStimulus(v, {$urandom, $urandom}, {$urandom, $urandom},
                          ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31)),
                          4'($urandom), 1'($urandom), 4'($urandom),
                          ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
            if (!v && $urandom_range(0, 1) == 1) begin
                ex_ctrl = 'x;
            end
            reset_n = ($urandom_range(0, 199) != 0);
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
